// File: rtl/matrix_dispatcher.sv
// Sequencer for the inner-product engine: holds host-loaded A/B, presents row i of A
// and column j of B for every (i,j) in row-major order, and stores each result in C.
module matrix_dispatcher #(
    parameter int unsigned N  = 4,
    parameter int unsigned AW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic            wr_sel,
    input  logic [AW-1:0]   wr_addr,
    input  logic [31:0]     wr_data,
    input  logic            start,
    output logic            busy,
    output logic            done,
    input  logic [AW-1:0]   rd_addr,
    output logic [31:0]     rd_data,
    output logic [32*N-1:0] row,
    output logic [32*N-1:0] column,
    output logic            row_o_stb,
    output logic            column_o_stb,
    input  logic            row_o_ack,
    input  logic            column_o_ack,
    input  logic [31:0]     res,
    input  logic            res_i_stb,
    output logic            res_i_ack
);
    localparam int unsigned LW = AW / 2;

    typedef enum logic [2:0] {
        IDLE,
        DISPATCH,
        WAIT_RES,
        ADVANCE,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [LW-1:0] i_q, i_d, j_q, j_d;
    logic          row_seen_q, row_seen_d;
    logic          col_seen_q, col_seen_d;
    logic          res_got_q, res_got_d;
    logic [31:0]   a_q [N*N];
    logic [31:0]   b_q [N*N];
    logic [31:0]   c_q [N*N];
    logic [31:0]   rd_data_q;
    logic [AW-1:0] c_idx;
    logic          c_we;
    logic          acks_done;
    logic          last_pair;

    assign c_idx     = {i_q, j_q};
    assign last_pair = &c_idx;
    assign acks_done = (row_seen_q | row_o_ack) & (col_seen_q | column_o_ack);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign rd_data   = rd_data_q;

    always_comb begin
        state_d      = state_q;
        i_d          = i_q;
        j_d          = j_q;
        row_seen_d   = row_seen_q;
        col_seen_d   = col_seen_q;
        res_got_d    = res_got_q;
        row_o_stb    = 1'b0;
        column_o_stb = 1'b0;
        res_i_ack    = 1'b0;
        c_we         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = DISPATCH;
                    i_d        = '0;
                    j_d        = '0;
                    row_seen_d = 1'b0;
                    col_seen_d = 1'b0;
                    res_got_d  = 1'b0;
                end
            end
            DISPATCH: begin
                row_o_stb    = 1'b1;
                column_o_stb = 1'b1;
                res_i_ack    = !res_got_q;
                row_seen_d   = row_seen_q | row_o_ack;
                col_seen_d   = col_seen_q | column_o_ack;
                // An early result is stored once; acks still gate leaving the dispatch.
                if (res_i_stb && !res_got_q) begin
                    c_we      = 1'b1;
                    res_got_d = 1'b1;
                end
                if (acks_done) begin
                    state_d = (res_got_q || res_i_stb) ? ADVANCE : WAIT_RES;
                end
            end
            WAIT_RES: begin
                res_i_ack = 1'b1;
                if (res_i_stb) begin
                    c_we    = 1'b1;
                    state_d = ADVANCE;
                end
            end
            ADVANCE: begin
                row_seen_d = 1'b0;
                col_seen_d = 1'b0;
                res_got_d  = 1'b0;
                // N is a power of two, so incrementing {i,j} steps j and carries into i.
                {i_d, j_d} = c_idx + 1'b1;
                state_d    = last_pair ? DONE : DISPATCH;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            i_q        <= '0;
            j_q        <= '0;
            row_seen_q <= 1'b0;
            col_seen_q <= 1'b0;
            res_got_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            j_q        <= j_d;
            row_seen_q <= row_seen_d;
            col_seen_q <= col_seen_d;
            res_got_q  <= res_got_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < N*N; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                c_q[k] <= '0;
            end
            rd_data_q <= '0;
        end else begin
            if (state_q == IDLE && wr_en) begin
                if (wr_sel) begin
                    b_q[wr_addr] <= wr_data;
                end else begin
                    a_q[wr_addr] <= wr_data;
                end
            end
            if (c_we) begin
                c_q[c_idx] <= res;
            end
            rd_data_q <= c_q[rd_addr];
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < N; k++) begin
            row[32*k +: 32]    = a_q[{i_q, LW'(k)}];
            column[32*k +: 32] = b_q[{LW'(k), j_q}];
        end
    end

endmodule

// File: doc/matrix_dispatcher.md
Name: matrix_dispatcher

Overview:
Initiator for the inner-product engine's row/column/result handshake. Holds matrices A and B (N x N, 32-bit IEEE-754 words) loaded by a host, then for every (i,j) presents row i of A and column j of B to the engine. It collects each scalar result into C[i][j]. It does no arithmetic, only sequencing, addressing and handshake control.

Parameters:
N, 4, matrix dimension (power of two, 2..8)
AW, 4, address width = 2*log2(N)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
wr_en  in  1  host write strobe for A/B
wr_sel  in  1  0 = A, 1 = B
wr_addr  in  AW  row-major element index (r*N+c)
wr_data  in  32  element value
start  in  1  begin multiplication (pulse)
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after last C write
rd_addr  in  AW  C read index (r*N+c)
rd_data  out  32  C[rd_addr], registered, 1-cycle latency
row  out  32*N  row i of A; element k at bits [32k+31:32k]
column  out  32*N  column j of B; element k = B[k][j], same slicing
row_o_stb  out  1  row valid
column_o_stb  out  1  column valid
row_o_ack  in  1  engine accepted row
column_o_ack  in  1  engine accepted column
res  in  32  engine result
res_i_stb  in  1  result valid
res_i_ack  out  1  dispatcher ready for result

Behaviour:
- Reset, synchronous, clk edge with rst=1: state IDLE. busy, done, row_o_stb, column_o_stb and res_i_ack are 0. rd_data = 0. A, B and C are all cleared to 0. i = j = 0. Ack-seen flags are cleared. Reset mid-operation aborts immediately; any engine result in flight is ignored.
- Writes: accepted only in IDLE when wr_en=1. Writes A or B at wr_addr. wr_en during busy is ignored.
- row and column are driven combinationally from A[i] and B[*][j] and are stable while the strobes are high.
- FSM:
  - IDLE: on start=1, go to DISPATCH next cycle, set busy=1, i=j=0. start while busy is ignored.
  - DISPATCH: row_o_stb = column_o_stb = res_i_ack = 1. Latch row_o_ack and column_o_ack independently into seen flags; the acks may arrive in different cycles. Once both have been seen (including the current cycle), drop both strobes next cycle and go to WAIT_RES. res_i_ack stays 1.
  - WAIT_RES: res_i_ack = 1. On res_i_stb=1, capture res into C[i*N+j], drop res_i_ack, go to ADVANCE. A res_i_stb that arrives while still in DISPATCH is also captured, and the FSM goes straight to ADVANCE once both acks have been seen.
  - ADVANCE, 1 cycle: clear the seen flags. If j<N-1 then j++; else j=0 and i++. If the last pair (i=j=N-1) was just stored, go to DONE; otherwise go to DISPATCH.
  - DONE: done=1 for one cycle, busy goes to 0 next cycle, state returns to IDLE. C holds its values until the next start or reset.
- Minimum dispatch latency: start accepted at cycle 0, strobes high at cycle 1.
- Order of dispatch is row-major (j inner). Exactly N*N dispatches and N*N C writes per start.
- rd_data updates every cycle from C[rd_addr], including while busy. A read of an entry written in the same cycle returns the old value.

Test Plan:
- Load A = identity (1.0 = 32'h3F800000 on the diagonal, 0 elsewhere) and B[k] = k as float. A behavioural engine acks in 1 cycle and returns its dot product after 5 cycles, then start -> C == B bitwise. done pulses exactly once. busy is high from cycle 1 through done.
- Engine acks row at cycle t and column at cycle t+3 -> strobes stay high until t+4. row and column are unchanged throughout. There is exactly one dispatch per (i,j).
- Engine returns res_i_stb in the same cycle as the second ack -> result is captured. The next dispatch goes to the next (i,j) with no duplicate write.
- Assert rst during dispatch (i=1, j=2) -> next cycle all strobes, busy and done are 0 and C reads 0. A later start completes a full N*N run normally.
- Pulse start and wr_en while busy -> both are ignored. Dispatch order is unchanged and A is unmodified (read back via a product run).
- Record the dispatch order with N=2 -> (0,0),(0,1),(1,0),(1,1). column for j=1 = {B[1][1],B[0][1]}, with B[0][1] in bits [31:0].
